// File: rtl/uart_rx_sampler.sv
// 16x-oversampling 8N1 receiver with 2-of-3 majority sampling, false-start
// rejection, framing-error strobe and break detection.
`timescale 1ns/1ps
module uart_rx_sampler #(
  parameter int clkfreq    = 50000000,
  parameter int baud       = 9600,
  parameter int oversample = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] data,
  output logic       ready,
  output logic       frame_err,
  output logic       break_det,
  output logic       busy
);

  localparam int DIV_RAW = clkfreq / (baud * oversample);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(oversample);
  localparam int M       = oversample / 2;

  localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(oversample - 1);
  localparam logic [SW-1:0] S_A    = SW'(M - 1);
  localparam logic [SW-1:0] S_B    = SW'(M);
  localparam logic [SW-1:0] S_C    = SW'(M + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          rx_m, rx_s;
  logic [TW-1:0] tcnt;
  logic          tick;
  state_t        state;
  logic [SW-1:0] s;
  logic [2:0]    bidx;
  logic          smp_a, smp_b, smp_c;
  logic [7:0]    shreg;
  logic          bit_val, stop_val;

  // stage: input synchroniser (idle-high so reset never looks like a start)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= serial_in;
      rx_s <= rx_m;
    end
  end

  // stage: free-running oversample tick, independent of line activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else if (tick) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  assign tick = (tcnt == T_LAST);

  assign bit_val  = maj3(smp_a, smp_b, smp_c);
  assign stop_val = maj3(smp_a, smp_b, rx_s);

  // stage: mid-bit samples and LSB-first shift register (datapath, no reset)
  always_ff @(posedge clk) begin
    if (tick && s == S_A) smp_a <= rx_s;
    if (tick && s == S_B) smp_b <= rx_s;
    if (tick && s == S_C) smp_c <= rx_s;
    if (tick && state == DATA && s == S_LAST) shreg <= {bit_val, shreg[7:1]};
  end

  // stage: frame FSM with registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      bidx      <= 3'd0;
      data      <= 8'h00;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state <= START;
              s     <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (s == S_LAST) begin
              s <= '0;
              if (bit_val) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= DATA;
                bidx  <= 3'd0;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
          DATA: begin
            if (s == S_LAST) begin
              s    <= '0;
              bidx <= bidx + 3'd1;
              if (bidx == 3'd7) state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
          STOP: begin
            // decide mid stop bit so a start edge right after it is caught
            if (s == S_C) begin
              s <= '0;
              if (stop_val) begin
                data  <= shreg;
                ready <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                if (shreg == 8'h00) begin
                  break_det <= 1'b1;
                  state     <= BREAK;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end else begin
              s <= s + 1'b1;
            end
          end
          BREAK: begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
